// File: rtl/xadac_obi_if.sv
// xadac_obi_if: OBI request/response channel bundle.
//   req/gnt/addr/we/be/wdata/aid : request channel, manager -> subordinate (gnt back)
//   rvalid/rready/rdata/rid      : response channel, subordinate -> manager (rready back)
interface xadac_obi_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned IdWidth   = 4
);
   logic                   req;
   logic                   gnt;
   logic [AddrWidth-1:0]   addr;
   logic                   we;
   logic [DataWidth/8-1:0] be;
   logic [DataWidth-1:0]   wdata;
   logic [IdWidth-1:0]     aid;
   logic                   rvalid;
   logic                   rready;
   logic [DataWidth-1:0]   rdata;
   logic [IdWidth-1:0]     rid;

   modport mst (
      output req, addr, we, be, wdata, aid, rready,
      input  gnt, rvalid, rdata, rid
   );

   modport slv (
      input  req, addr, we, be, wdata, aid, rready,
      output gnt, rvalid, rdata, rid
   );
endinterface

// File: rtl/xadac_obi_sram_bridge.sv
// xadac_obi_sram_bridge: OBI subordinate onto a 1-cycle-latency single-port SRAM.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   obi           : OBI subordinate port (request accepted on req && gnt)
//   mem_*_o       : SRAM strobe/we/word index/byte enables/write data
//   mem_rdata_i   : SRAM read data, valid the cycle after mem_req_o
// Responses are queued in an in-order FIFO; a credit counter covering the
// in-flight SRAM access plus FIFO occupancy throttles gnt so it never overflows.
module xadac_obi_sram_bridge #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned NumWords  = 1024,
   parameter int unsigned RspDepth  = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   xadac_obi_if.slv                    obi,
   output logic                        mem_req_o,
   output logic                        mem_we_o,
   output logic [$clog2(NumWords)-1:0] mem_addr_o,
   output logic [DataWidth/8-1:0]      mem_be_o,
   output logic [DataWidth-1:0]        mem_wdata_o,
   input  logic [DataWidth-1:0]        mem_rdata_i
);
   localparam int unsigned CntW = $clog2(RspDepth + 1);
   localparam int unsigned PtrW = RspDepth > 1 ? $clog2(RspDepth) : 1;
   localparam logic [CntW-1:0] CntMax  = CntW'(RspDepth);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(RspDepth - 1);

   logic [CntW-1:0]      cnt;
   logic                 inf_valid;
   logic                 inf_we;
   logic [IdWidth-1:0]   inf_aid;
   logic [PtrW-1:0]      wptr;
   logic [PtrW-1:0]      rptr;
   logic [DataWidth-1:0] fifo_data [RspDepth];
   logic [IdWidth-1:0]   fifo_id   [RspDepth];
   logic                 gnt;
   logic                 accept;
   logic                 rvalid;
   logic                 pop;
   logic [AddrWidth-1:0] unused_addr;

   assign unused_addr = obi.addr;

   assign gnt    = cnt < CntMax;
   assign accept = obi.req && gnt;
   // cnt counts the in-flight entry plus FIFO entries, so the FIFO is non-empty
   // exactly when cnt exceeds the in-flight contribution.
   assign rvalid = cnt > CntW'(inf_valid);
   assign pop    = rvalid && obi.rready;

   assign obi.gnt    = gnt;
   assign obi.rvalid = rvalid;
   assign obi.rdata  = rvalid ? fifo_data[rptr] : '0;
   assign obi.rid    = rvalid ? fifo_id[rptr] : '0;

   // SRAM strobes are gated by accept so the macro sees nothing while idle.
   assign mem_req_o   = accept;
   assign mem_we_o    = accept && obi.we;
   assign mem_addr_o  = accept ? obi.addr[$clog2(DataWidth/8) +: $clog2(NumWords)] : '0;
   assign mem_be_o    = accept ? obi.be : '0;
   assign mem_wdata_o = accept ? obi.wdata : '0;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         cnt       <= '0;
         inf_valid <= 1'b0;
         inf_we    <= 1'b0;
         inf_aid   <= '0;
         wptr      <= '0;
         rptr      <= '0;
      end else begin
         cnt       <= cnt + CntW'(accept) - CntW'(pop);
         inf_valid <= accept;
         if (accept) begin
            inf_we  <= obi.we;
            inf_aid <= obi.aid;
         end
         if (inf_valid) wptr <= wptr == PtrLast ? '0 : wptr + 1'b1;
         if (pop) rptr <= rptr == PtrLast ? '0 : rptr + 1'b1;
      end

   // Storage needs no reset: entries are only visible once counted by cnt.
   always_ff @(posedge clk_i)
      if (inf_valid) begin
         fifo_data[wptr] <= inf_we ? '0 : mem_rdata_i;
         fifo_id[wptr]   <= inf_aid;
      end
endmodule

// File: tb/tb_xadac_obi_sram_bridge.sv
// tb_xadac_obi_sram_bridge: directed and randomized checks of the OBI-SRAM bridge
// against a transaction-level model (word array + outstanding-response queue).
module tb_xadac_obi_sram_bridge;
   localparam int unsigned NumWords = 1024;
   localparam int unsigned RspDepth = 4;

   typedef struct {
      logic [63:0] d;
      logic [3:0]  id;
      int          t;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req, mem_we;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_be;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic [63:0] sram    [NumWords] = '{default: '0};
   logic [63:0] ref_mem [NumWords] = '{default: '0};

   rsp_t        q[$];
   int          cycle = 0;
   int          ntot = 0, npass = 0, nfail = 0;
   int          rmode = 0;
   logic        last_acc = 1'b0;
   logic [63:0] last_pop_data = '0;
   logic [3:0]  last_pop_id = '0;

   xadac_obi_if #(.AddrWidth(32), .DataWidth(64), .IdWidth(4)) obi ();

   xadac_obi_sram_bridge #(
      .AddrWidth(32), .DataWidth(64), .IdWidth(4), .NumWords(NumWords), .RspDepth(RspDepth)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .obi(obi),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk)
      if (mem_req) begin
         if (mem_we) begin
            for (int b = 0; b < 8; b++)
               if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end else mem_rdata <= sram[mem_addr];
      end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive rready, check outputs against the model at negedge, then
   // advance the model at the posedge. Called at posedge+1.
   task automatic tick();
      logic eg, ev, acc, pp;
      int unsigned idx;
      obi.rready = (rmode == 0) || (rmode == 2 && $urandom_range(0, 1) == 1);
      @(negedge clk);
      eg = q.size() < RspDepth;
      ev = q.size() > 0 && q[0].t <= cycle;
      chk("gnt", obi.gnt, eg);
      chk("rvalid", obi.rvalid, ev);
      if (ev) begin
         chk("rdata", obi.rdata, q[0].d);
         chk("rid", obi.rid, q[0].id);
      end
      acc = obi.req && eg;
      idx = (obi.addr / 8) % NumWords;
      chk("mem_req", mem_req, acc);
      if (acc) begin
         chk("mem_addr", mem_addr, idx);
         chk("mem_we", mem_we, obi.we);
         chk("mem_be", mem_be, obi.be);
         chk("mem_wdata", mem_wdata, obi.wdata);
      end
      pp = ev && obi.rready;
      if (pp) begin
         last_pop_data = obi.rdata;
         last_pop_id   = obi.rid;
      end
      @(posedge clk);
      cycle++;
      if (pp) void'(q.pop_front());
      if (acc) begin
         q.push_back('{d: obi.we ? 64'd0 : ref_mem[idx], id: obi.aid, t: cycle + 1});
         if (obi.we)
            for (int b = 0; b < 8; b++)
               if (obi.be[b]) ref_mem[idx][b*8 +: 8] = obi.wdata[b*8 +: 8];
      end
      last_acc = acc;
      #1;
   endtask

   task automatic issue(input logic we, input logic [31:0] addr, input logic [7:0] be,
                        input logic [63:0] wd, input logic [3:0] aid);
      int n;
      n = 0;
      obi.req = 1'b1; obi.we = we; obi.addr = addr; obi.be = be; obi.wdata = wd; obi.aid = aid;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 40);
      chk("accepted", last_acc, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      obi.req = 1'b0;
      rmode = 0;
      while (q.size() > 0 && n < 60) begin
         tick();
         n++;
      end
      chk("drain_done", q.size(), 0);
      tick();
   endtask

   initial begin
      int n_acc, c0;
      logic [63:0] x;
      obi.req = 1'b0; obi.we = 1'b0; obi.addr = '0; obi.be = '0; obi.wdata = '0;
      obi.aid = '0; obi.rready = 1'b1;
      @(posedge clk); #1;
      chk("rst_gnt", obi.gnt, 1'b1);
      chk("rst_rvalid", obi.rvalid, 1'b0);
      chk("rst_rdata", obi.rdata, 64'd0);
      chk("rst_rid", obi.rid, 4'd0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 10'd0);
      chk("rst_mem_be", mem_be, 8'd0);
      chk("rst_mem_wdata", mem_wdata, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // write then read
      issue(1'b1, 32'h18, 8'hFF, 64'hDEADBEEF_CAFEF00D, 4'd3);
      issue(1'b0, 32'h18, 8'h00, 64'd0, 4'd5);
      drain();
      chk("wr_rd_data", last_pop_data, 64'hDEADBEEF_CAFEF00D);
      chk("wr_rd_id", last_pop_id, 4'd5);

      // byte enables
      issue(1'b1, 32'h10, 8'hFF, '1, 4'd1);
      issue(1'b1, 32'h10, 8'h0F, 64'd0, 4'd2);
      issue(1'b0, 32'h10, 8'h00, 64'd0, 4'd3);
      drain();
      chk("be_merge", last_pop_data, 64'hFFFFFFFF_00000000);

      // zero byte enables still strobe and respond
      issue(1'b1, 32'h10, 8'h00, 64'h1234, 4'd7);
      issue(1'b0, 32'h10, 8'h00, 64'd0, 4'd8);
      drain();
      chk("be_zero", last_pop_data, 64'hFFFFFFFF_00000000);

      // credit limit under backpressure
      rmode = 1;
      n_acc = 0;
      obi.req = 1'b1; obi.we = 1'b0; obi.addr = 32'h18; obi.aid = 4'd0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (last_acc) begin
            n_acc++;
            obi.aid = obi.aid + 4'd1;
         end
      end
      chk("credit_accepts", n_acc, 4);
      chk("gnt_full", obi.gnt, 1'b0);
      obi.req = 1'b0;
      rmode = 0;
      tick();
      rmode = 1;
      chk("bp_first_id", last_pop_id, 4'd0);
      chk("gnt_after_pop", obi.gnt, 1'b1);
      tick();
      drain();
      chk("bp_last_id", last_pop_id, 4'd3);

      // streaming
      c0 = cycle;
      for (int i = 0; i < 16; i++) issue(1'b0, 32'(i * 8), 8'h00, 64'd0, 4'(i));
      chk("stream_cycles", cycle - c0, 16);
      drain();
      chk("stream_last_id", last_pop_id, 4'd15);

      // aliasing
      x = 64'h0102030405060708;
      issue(1'b1, 32'd40, 8'hFF, x, 4'd9);
      issue(1'b0, 32'((NumWords + 5) * 8), 8'h00, 64'd0, 4'd10);
      drain();
      chk("alias_data", last_pop_data, x);

      // reset with responses buffered
      rmode = 1;
      for (int i = 0; i < 3; i++) issue(1'b0, 32'(i * 8), 8'h00, 64'd0, 4'(i));
      obi.req = 1'b0;
      tick();
      tick();
      chk("pre_rst_rvalid", obi.rvalid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rvalid", obi.rvalid, 1'b0);
      chk("mid_rst_gnt", obi.gnt, 1'b1);
      q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      rmode = 0;
      for (int i = 0; i < 4; i++) tick();
      rmode = 1;
      n_acc = 0;
      obi.req = 1'b1; obi.we = 1'b0; obi.addr = 32'h0; obi.aid = 4'd0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (last_acc) n_acc++;
      end
      chk("post_rst_credits", n_acc, 4);
      drain();

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         rmode = 2;
         if ($urandom_range(0, 3) == 0) begin
            obi.req = 1'b0;
            tick();
         end
         issue($urandom_range(0, 1) == 1,
               32'($urandom_range(0, 31) * 8 + $urandom_range(0, 7) + $urandom_range(0, 3) * NumWords * 8),
               8'($urandom), {$urandom, $urandom}, 4'($urandom));
      end
      drain();

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
